// File: rtl/datapath_pkg.sv
//==============================================================================
// datapath_pkg : bus source codes, enable-vector bit indices and ALU op codes
// Rev 1.0
//==============================================================================
`default_nettype none

package datapath_pkg;

    localparam logic [3:0] SRC_NONE = 4'd0;
    localparam logic [3:0] SRC_PC   = 4'd1;
    localparam logic [3:0] SRC_AR   = 4'd2;
    localparam logic [3:0] SRC_IR   = 4'd4;
    localparam logic [3:0] SRC_AC   = 4'd5;
    localparam logic [3:0] SRC_R    = 4'd6;
    localparam logic [3:0] SRC_R1   = 4'd7;
    localparam logic [3:0] SRC_R2   = 4'd8;
    localparam logic [3:0] SRC_R3   = 4'd9;
    localparam logic [3:0] SRC_R4   = 4'd10;
    localparam logic [3:0] SRC_DM   = 4'd12;
    localparam logic [3:0] SRC_IM   = 4'd13;

    localparam int unsigned WB_PC  = 1;
    localparam int unsigned WB_AR  = 2;
    localparam int unsigned WB_IR  = 3;
    localparam int unsigned WB_AC  = 4;
    localparam int unsigned WB_R   = 5;
    localparam int unsigned WB_R4  = 7;
    localparam int unsigned WB_R3  = 8;
    localparam int unsigned WB_R2  = 9;
    localparam int unsigned WB_R1  = 10;
    localparam int unsigned WB_DM  = 11;
    localparam int unsigned WB_ALU = 12;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MUL  = 3'd3;
    localparam logic [2:0] ALU_LSH  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/datapath_alu.sv
//==============================================================================
// alu : combinational ALU on AC and R, result truncated to DATA_W
// Rev 1.0
//==============================================================================
`default_nettype none

module alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_MUL: result = a * b;
            ALU_LSH: result = a << 1;
            default: result = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/datapath.sv
//==============================================================================
// datapath : register file, shared bus, ALU and memory ports for the control FSM
// Rev 1.0
//==============================================================================
`default_nettype none

module datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [2:0]        alu_op,
    input  logic              end_process,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic [5:0]        instruction,
    output logic [15:0]       z,
    output logic              done
);

    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DATA_W-1:0] ir_q, ir_d, ac_q, ac_d, r_q, r_d;
    logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] w_bus;
    logic              w_bus_valid;
    logic              w_bus_ok;
    logic              w_run;
    logic [DATA_W-1:0] w_alu;
    logic              w_unused;

    always_comb begin
        w_bus       = '0;
        w_bus_valid = 1'b1;
        case (read_en)
            SRC_PC:  w_bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            SRC_AR:  w_bus = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
            SRC_IR:  w_bus = ir_q;
            SRC_AC:  w_bus = ac_q;
            SRC_R:   w_bus = r_q;
            SRC_R1:  w_bus = r1_q;
            SRC_R2:  w_bus = r2_q;
            SRC_R3:  w_bus = r3_q;
            SRC_R4:  w_bus = r4_q;
            SRC_DM:  w_bus = dm_rdata;
            SRC_IM:  w_bus = im_rdata;
            default: w_bus_valid = 1'b0;
        endcase
    end

    alu #(.DATA_W(DATA_W)) u_alu (
        .a      (ac_q),
        .b      (r_q),
        .op     (alu_op),
        .result (w_alu)
    );

    // Once halted every enable is masked; bus writes additionally need a valid source.
    assign w_run    = ~done_q;
    assign w_bus_ok = w_run & w_bus_valid;

    always_comb begin
        pc_d   = pc_q;
        ar_d   = ar_q;
        ir_d   = ir_q;
        ac_d   = ac_q;
        r_d    = r_q;
        r1_d   = r1_q;
        r2_d   = r2_q;
        r3_d   = r3_q;
        r4_d   = r4_q;
        done_d = done_q | end_process;

        if (w_run && clr_en[WB_PC])                pc_d = '0;
        else if (w_bus_ok && write_en[WB_PC])      pc_d = w_bus[ADDR_W-1:0];
        else if (w_run && inc_en[WB_PC])           pc_d = pc_q + ADDR_W'(1);

        if (w_run && clr_en[WB_AR])                ar_d = '0;
        else if (w_bus_ok && write_en[WB_AR])      ar_d = w_bus[ADDR_W-1:0];

        if (w_run && clr_en[WB_AC])                ac_d = '0;
        else if (w_run && write_en[WB_ALU])        ac_d = w_alu;
        else if (w_bus_ok && write_en[WB_AC])      ac_d = w_bus;
        else if (w_run && inc_en[WB_AC])           ac_d = ac_q + DATA_W'(1);

        if (w_bus_ok && write_en[WB_IR]) ir_d = w_bus;
        if (w_bus_ok && write_en[WB_R])  r_d  = w_bus;
        if (w_bus_ok && write_en[WB_R1]) r1_d = w_bus;
        if (w_bus_ok && write_en[WB_R2]) r2_d = w_bus;
        if (w_bus_ok && write_en[WB_R3]) r3_d = w_bus;
        if (w_bus_ok && write_en[WB_R4]) r4_d = w_bus;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= '0;
            ar_q   <= '0;
            ir_q   <= '0;
            ac_q   <= '0;
            r_q    <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
            r4_q   <= '0;
            done_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ar_q   <= ar_d;
            ir_q   <= ir_d;
            ac_q   <= ac_d;
            r_q    <= r_d;
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            r3_q   <= r3_d;
            r4_q   <= r4_d;
            done_q <= done_d;
        end
    end

    assign im_addr     = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = w_bus;
    assign dm_we       = w_bus_ok & write_en[WB_DM];
    assign instruction = ir_q[5:0];
    assign z           = {15'b0, (ac_q == '0)};
    assign done        = done_q;

    assign w_unused = ^{write_en[15:13], write_en[6], write_en[0],
                        inc_en[15:5], inc_en[3:2], inc_en[0],
                        clr_en[15:5], clr_en[3], clr_en[0]};

endmodule

`default_nettype wire
